// File: rtl/regfile_context_engine.sv
// Save/restore engine for the 32x32 register file: streams x1..x31 out through read port 1 (SAVE)
// or writes x1..x31 from an input stream through the write port (RESTORE); one word per cycle max.
module regfile_context_engine #(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 5,
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_save,
  input  logic              cmd_restore,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_a1,
  input  logic [XLEN-1:0]   rf_rd1,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [XLEN-1:0]   rf_di3,
  output logic              rf_we3,
  output logic [XLEN-1:0]   out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [XLEN-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAVE,
    ST_RESTORE,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  // Set once LAST_REG has been captured; the index itself wraps to 0 and cannot tell us.
  logic              rd_last_q, rd_last_d;
  logic              capture;
  logic              out_hs;

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  always_comb begin
    state_d     = state_q;
    rd_idx_d    = rd_idx_q;
    wr_idx_d    = wr_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rd_last_d   = rd_last_q;
    busy        = 1'b0;
    done        = 1'b0;
    rf_a1       = '0;
    rf_a3       = '0;
    rf_di3      = '0;
    rf_we3      = 1'b0;
    in_ready    = 1'b0;
    capture     = 1'b0;
    out_hs      = out_valid_q && out_ready;

    case (state_q)
      ST_IDLE: begin
        if (cmd_save) begin
          state_d = ST_SAVE;
        end else if (cmd_restore) begin
          state_d = ST_RESTORE;
        end
      end

      ST_SAVE: begin
        busy    = 1'b1;
        rf_a1   = rd_idx_q;
        capture = !rd_last_q && (!out_valid_q || out_ready);
        if (capture) begin
          out_data_d  = rf_rd1;
          out_valid_d = 1'b1;
          rd_idx_d    = rd_idx_q + ADDR_W'(1);
          rd_last_d   = (rd_idx_q == LAST_IDX);
        end else if (out_hs) begin
          out_valid_d = 1'b0;
          if (rd_last_q) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_RESTORE: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        rf_a3    = wr_idx_q;
        rf_di3   = in_data;
        rf_we3   = in_valid;
        if (in_valid) begin
          wr_idx_d = wr_idx_q + ADDR_W'(1);
          if (wr_idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done      = 1'b1;
        rd_idx_d  = FIRST_IDX;
        wr_idx_d  = FIRST_IDX;
        rd_last_d = 1'b0;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rd_idx_q    <= FIRST_IDX;
      wr_idx_q    <= FIRST_IDX;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_idx_q    <= rd_idx_d;
      wr_idx_q    <= wr_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      rd_last_q   <= rd_last_d;
    end
  end

endmodule
